mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 174 +++++++++++++++++
 tb/tb_mem_access.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through and runs one
// aligned word load/store at a time on the data bus, with timeout and flush.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [1:0]  memop_i,
  input  logic [4:0]  wreg_addr_i,
  input  logic        wreg_enable_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] store_data_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wreg_addr_o,
  output logic        wreg_enable_o,
  output logic [31:0] wdata_o,
  output logic        align_err_o,
  output logic        bus_err_o
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        lat_load_q, lat_load_d;
  logic [4:0]  lat_waddr_q, lat_waddr_d;
  logic        lat_wen_q, lat_wen_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, sdata_q, sdata_d;
  logic        wbv_q, wbv_d, wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        aerr_q, aerr_d, berr_q, berr_d;
  logic        is_mem, kill_now;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    kill_d      = kill_q;
    lat_load_d  = lat_load_q;
    lat_waddr_d = lat_waddr_q;
    lat_wen_d   = lat_wen_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    wbv_d       = 1'b0;
    wen_d       = 1'b0;
    waddr_d     = waddr_q;
    wdat_d      = wdat_q;
    aerr_d      = 1'b0;
    berr_d      = 1'b0;
    is_mem      = (memop_i == 2'b01) || (memop_i == 2'b10);
    kill_now    = kill_q | flush_i;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          if (!is_mem) begin
            wbv_d   = 1'b1;
            waddr_d = wreg_addr_i;
            wen_d   = wreg_enable_i;
            wdat_d  = wdata_i;
          end else if (wdata_i[1:0] != 2'b00) begin
            wbv_d   = 1'b1;
            waddr_d = wreg_addr_i;
            wdat_d  = wdata_i;
            aerr_d  = 1'b1;
          end else begin
            lat_load_d  = (memop_i == 2'b01);
            lat_waddr_d = wreg_addr_i;
            lat_wen_d   = wreg_enable_i;
            req_d       = 1'b1;
            we_d        = (memop_i == 2'b10);
            addr_d      = wdata_i;
            sdata_d     = store_data_i;
            cnt_d       = '0;
            kill_d      = 1'b0;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        kill_d = kill_now;
        // Acknowledge is checked first so it wins over a coincident timeout.
        if (dbus_ack_i) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wbv_d   = 1'b1;
          waddr_d = lat_waddr_q;
          wdat_d  = lat_load_q ? dbus_rdata_i : addr_q;
          wen_d   = lat_load_q & lat_wen_q & ~kill_now;
          kill_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wbv_d   = 1'b1;
          waddr_d = lat_waddr_q;
          wdat_d  = addr_q;
          berr_d  = 1'b1;
          kill_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      kill_q      <= 1'b0;
      lat_load_q  <= 1'b0;
      lat_waddr_q <= '0;
      lat_wen_q   <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sdata_q     <= '0;
      wbv_q       <= 1'b0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      wdat_q      <= '0;
      aerr_q      <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      kill_q      <= kill_d;
      lat_load_q  <= lat_load_d;
      lat_waddr_q <= lat_waddr_d;
      lat_wen_q   <= lat_wen_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      wbv_q       <= wbv_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      wdat_q      <= wdat_d;
      aerr_q      <= aerr_d;
      berr_q      <= berr_d;
    end
  end

  // Reset gates ready combinationally so it drops without waiting for an edge.
  assign ready_o       = rst & (state_q == IDLE);
  assign dbus_req_o    = req_q;
  assign dbus_we_o     = we_q;
  assign dbus_addr_o   = addr_q;
  assign dbus_wdata_o  = sdata_q;
  assign wb_valid_o    = wbv_q;
  assign wreg_addr_o   = waddr_q;
  assign wreg_enable_o = wen_q;
  assign wdata_o       = wdat_q;
  assign align_err_o   = aerr_q;
  assign bus_err_o     = berr_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, load/store, alignment,
// timeout, flush handling and asynchronous reset.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  memop_i = 2'b00;
  logic [4:0]  wreg_addr_i = '0;
  logic        wreg_enable_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] store_data_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic        dbus_ack_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wreg_addr_o;
  logic        wreg_enable_o;
  logic [31:0] wdata_o;
  logic        align_err_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .memop_i(memop_i),
    .wreg_addr_i(wreg_addr_i), .wreg_enable_i(wreg_enable_i), .wdata_i(wdata_i),
    .store_data_i(store_data_i), .flush_i(flush_i), .ready_o(ready_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .wb_valid_o(wb_valid_o), .wreg_addr_o(wreg_addr_o), .wreg_enable_o(wreg_enable_o),
    .wdata_o(wdata_o), .align_err_o(align_err_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] ra, input logic en,
                       input logic [31:0] d, input logic [31:0] sd);
    valid_i = 1'b1; memop_i = op; wreg_addr_i = ra; wreg_enable_i = en;
    wdata_i = d; store_data_i = sd;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ready_o, dbus_req_o, wb_valid_o, align_err_o, bus_err_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b req=%b wbv=%b ae=%b be=%b, want all 0",
               ready_o, dbus_req_o, wb_valid_o, align_err_o, bus_err_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", ready_o);
    end
  endtask

  task automatic test_alu();
    issue(2'b00, 5'd5, 1'b1, 32'h0000_00F0, 32'h0);
    step();
    checks++;
    if ({wb_valid_o, wreg_addr_o, wreg_enable_o, wdata_o, ready_o, dbus_req_o} !==
        {1'b1, 5'd5, 1'b1, 32'h0000_00F0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL alu_wb: got v=%b a=%0d e=%b d=%h want v=1 a=5 e=1 d=000000f0",
               wb_valid_o, wreg_addr_o, wreg_enable_o, wdata_o);
    end
    issue(2'b11, 5'd0, 1'b1, 32'hCAFE_0001, 32'h0);
    step();
    checks++;
    if ({wb_valid_o, wreg_addr_o, wreg_enable_o, wdata_o, dbus_req_o} !==
        {1'b1, 5'd0, 1'b1, 32'hCAFE_0001, 1'b0}) begin
      errors++;
      $display("FAIL reserved_r0_wb: got v=%b a=%0d e=%b d=%h req=%b want v=1 a=0 e=1 d=cafe0001 req=0",
               wb_valid_o, wreg_addr_o, wreg_enable_o, wdata_o, dbus_req_o);
    end
    valid_i = 1'b0;
    step();
    checks++;
    if ({wb_valid_o, wreg_enable_o} !== 2'b00) begin
      errors++; $display("FAIL alu_pulse: got v=%b e=%b want 0 0", wb_valid_o, wreg_enable_o);
    end
  endtask

  task automatic test_load();
    issue(2'b01, 5'd7, 1'b1, 32'h0000_0100, 32'h0);
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({dbus_req_o, dbus_we_o, dbus_addr_o, ready_o, wb_valid_o} !==
          {1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL load_wait%0d: got req=%b we=%b addr=%h rdy=%b wbv=%b want 1 0 00000100 0 0",
                 i, dbus_req_o, dbus_we_o, dbus_addr_o, ready_o, wb_valid_o);
      end
      if (i < 3) step();
    end
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEAD_BEEF;
    step();
    dbus_ack_i = 1'b0;
    checks++;
    if ({wb_valid_o, wreg_addr_o, wreg_enable_o, wdata_o, dbus_req_o, ready_o, bus_err_o} !==
        {1'b1, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_wb: got v=%b a=%0d e=%b d=%h req=%b rdy=%b be=%b want 1 7 1 deadbeef 0 1 0",
               wb_valid_o, wreg_addr_o, wreg_enable_o, wdata_o, dbus_req_o, ready_o, bus_err_o);
    end
  endtask

  task automatic test_store();
    issue(2'b10, 5'd3, 1'b1, 32'h0000_0200, 32'h1234_5678);
    step();
    valid_i = 1'b0;
    checks++;
    if ({dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o} !==
        {1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678}) begin
      errors++;
      $display("FAIL store_req: got req=%b we=%b addr=%h wd=%h want 1 1 00000200 12345678",
               dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o);
    end
    dbus_ack_i = 1'b1;
    step();
    dbus_ack_i = 1'b0;
    checks++;
    if ({wb_valid_o, wreg_enable_o, wdata_o, dbus_req_o, ready_o} !==
        {1'b1, 1'b0, 32'h0000_0200, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL store_wb: got v=%b e=%b d=%h req=%b rdy=%b want 1 0 00000200 0 1",
               wb_valid_o, wreg_enable_o, wdata_o, dbus_req_o, ready_o);
    end
    step();
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL store_pulse: got v=%b want 0", wb_valid_o);
    end
  endtask

  task automatic test_misalign();
    issue(2'b01, 5'd4, 1'b1, 32'h0000_0102, 32'h0);
    step();
    valid_i = 1'b0;
    checks++;
    if ({dbus_req_o, align_err_o, wb_valid_o, wreg_enable_o, ready_o} !== 5'b01101) begin
      errors++;
      $display("FAIL misalign: got req=%b ae=%b v=%b e=%b rdy=%b want 0 1 1 0 1",
               dbus_req_o, align_err_o, wb_valid_o, wreg_enable_o, ready_o);
    end
    step();
    checks++;
    if ({align_err_o, wb_valid_o} !== 2'b00) begin
      errors++; $display("FAIL misalign_pulse: got ae=%b v=%b want 0 0", align_err_o, wb_valid_o);
    end
  endtask

  task automatic test_timeout();
    issue(2'b01, 5'd8, 1'b1, 32'h0000_0300, 32'h0);
    step();
    valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({dbus_req_o, bus_err_o} !== 2'b10) begin
        errors++;
        $display("FAIL timeout_wait%0d: got req=%b be=%b want 1 0", i, dbus_req_o, bus_err_o);
      end
      step();
    end
    checks++;
    if ({dbus_req_o, bus_err_o, wb_valid_o, wreg_enable_o, ready_o} !== 5'b01101) begin
      errors++;
      $display("FAIL timeout_end: got req=%b be=%b v=%b e=%b rdy=%b want 0 1 1 0 1",
               dbus_req_o, bus_err_o, wb_valid_o, wreg_enable_o, ready_o);
    end
    step();
    checks++;
    if ({bus_err_o, wb_valid_o} !== 2'b00) begin
      errors++; $display("FAIL timeout_pulse: got be=%b v=%b want 0 0", bus_err_o, wb_valid_o);
    end
  endtask

  task automatic test_flush();
    issue(2'b01, 5'd9, 1'b1, 32'h0000_0400, 32'h0);
    step();
    valid_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    checks++;
    if (dbus_req_o !== 1'b1) begin
      errors++; $display("FAIL flush_keeps_req: got req=%b want 1", dbus_req_o);
    end
    dbus_ack_i = 1'b1; dbus_rdata_i = 32'hAAAA_5555;
    step();
    dbus_ack_i = 1'b0;
    checks++;
    if ({wb_valid_o, wreg_enable_o, wdata_o} !== {1'b1, 1'b0, 32'hAAAA_5555}) begin
      errors++;
      $display("FAIL flush_wait_wb: got v=%b e=%b d=%h want 1 0 aaaa5555",
               wb_valid_o, wreg_enable_o, wdata_o);
    end
    issue(2'b01, 5'd2, 1'b1, 32'h0000_0600, 32'h0);
    flush_i = 1'b1;
    step();
    valid_i = 1'b0; flush_i = 1'b0;
    checks++;
    if ({wb_valid_o, dbus_req_o, ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL flush_idle: got v=%b req=%b rdy=%b want 0 0 1", wb_valid_o, dbus_req_o, ready_o);
    end
    dbus_ack_i = 1'b1;
    step();
    dbus_ack_i = 1'b0;
    checks++;
    if ({wb_valid_o, dbus_req_o, ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL ack_idle: got v=%b req=%b rdy=%b want 0 0 1", wb_valid_o, dbus_req_o, ready_o);
    end
  endtask

  task automatic test_reset_wait();
    issue(2'b01, 5'd6, 1'b1, 32'h0000_0500, 32'h0);
    step();
    valid_i = 1'b0;
    checks++;
    if (dbus_req_o !== 1'b1) begin
      errors++; $display("FAIL rst_wait_pre: got req=%b want 1", dbus_req_o);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({dbus_req_o, ready_o, wb_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL rst_wait_async: got req=%b rdy=%b v=%b want 0 0 0", dbus_req_o, ready_o, wb_valid_o);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_wait_release: got rdy=%b want 1", ready_o);
    end
  endtask

  task automatic test_back_to_back();
    issue(2'b00, 5'd10, 1'b1, 32'h0000_0011, 32'h0);
    step();
    issue(2'b00, 5'd11, 1'b1, 32'h0000_0022, 32'h0);
    checks++;
    if ({wb_valid_o, wreg_addr_o, wdata_o} !== {1'b1, 5'd10, 32'h0000_0011}) begin
      errors++;
      $display("FAIL b2b_first: got v=%b a=%0d d=%h want 1 10 00000011", wb_valid_o, wreg_addr_o, wdata_o);
    end
    step();
    valid_i = 1'b0;
    checks++;
    if ({wb_valid_o, wreg_addr_o, wdata_o} !== {1'b1, 5'd11, 32'h0000_0022}) begin
      errors++;
      $display("FAIL b2b_second: got v=%b a=%0d d=%h want 1 11 00000022", wb_valid_o, wreg_addr_o, wdata_o);
    end
    step();
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got v=%b want 0", wb_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_flush();
    test_reset_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
